// File: rtl/ws_tile_sequencer.sv
// ---------------------------------------------------------------------------
// ws_tile_sequencer
//
// Purpose:
//   Sequences one weight-stationary tile run on the systolic core by emitting
//   a registered 52-bit instruction word every cycle:
//     load ROW weight words from pmem into L0, push them into the array,
//     let them settle, stream act_len activation vectors from xmem through
//     L0 into the array, wait for the output FIFO, then move act_len result
//     vectors from the output FIFO into omem.
//
// Ports:
//   clk          single clock, rising-edge active
//   reset        asynchronous, active-high; aborts any run
//   start        request one run (sampled only when idle)
//   wt_base      pmem start address      (sampled with start)
//   act_base     xmem start address      (sampled with start)
//   out_base     omem start address      (sampled with start)
//   act_len      activation/output vector count (sampled with start)
//   ofifo_valid  core output FIFO holds at least one vector
//   inst         registered core instruction word
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse when a run completes
//
// Instruction word layout:
//   [51] 0 | [50] CEN_omem [49] WEN_omem [48:38] A_omem
//   [37] all_row_mode [36] l0_rd_mode [35] mode [34] data_mode [33] acc
//   [32] CEN_pmem [31] WEN_pmem [30:20] A_pmem
//   [19] CEN_xmem [18] WEN_xmem [17:7] A_xmem
//   [6] ofifo_rd [5] ififo_wr [4] ififo_rd [3] l0_rd [2] l0_wr
//   [1] execute [0] load
// ---------------------------------------------------------------------------
module ws_tile_sequencer #(
    parameter int ROW = 8,
    parameter int COL = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] wt_base,
    input  logic [10:0] act_base,
    input  logic [10:0] out_base,
    input  logic [10:0] act_len,
    input  logic        ofifo_valid,
    output logic [51:0] inst,
    output logic        busy,
    output logic        done
);

    // All SRAMs disabled, no writes, weight-stationary mode, nothing else.
    localparam logic [51:0] IDLE_WORD = 52'h6_0009_800C_0000;

    localparam int              CNT_W    = 16;
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW);
    localparam logic [CNT_W-1:0] ROW_M1   = CNT_W'(ROW - 1);

    // Elaboration-time guard against degenerate array shapes.
    if (ROW < 1 || ROW > 2048 || COL < 1) begin : g_param_check
        $error("ws_tile_sequencer: ROW must be 1..2048 and COL must be >= 1");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_WT_RD,
        S_KER_LD,
        S_KER_WAIT,
        S_ACT_RD,
        S_EXEC,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [10:0]        rd_cnt_q, rd_cnt_d;
    logic [10:0]        wr_cnt_q, wr_cnt_d;
    logic [10:0]        wt_base_q, wt_base_d;
    logic [10:0]        act_base_q, act_base_d;
    logic [10:0]        out_base_q, out_base_d;
    logic [10:0]        len_q, len_d;
    logic [51:0]        inst_q, inst_d;
    logic               done_q, done_d;

    logic               rd_fire;
    logic               wr_fire;

    // A FIFO read is issued whenever data is present and reads remain; the
    // matching omem write follows one cycle after the read appears on inst.
    assign rd_fire = (state_q == S_OUT) && ofifo_valid && (rd_cnt_q < len_q);
    assign wr_fire = (state_q == S_OUT) && inst_q[6];

    // Run parameters are captured only on an accepted start so that input
    // changes during a run cannot disturb it. The first word of the run is
    // built from the incoming values, hence the bypass.
    always_comb begin
        wt_base_d  = wt_base_q;
        act_base_d = act_base_q;
        out_base_d = out_base_q;
        len_d      = len_q;
        if (state_q == S_IDLE && start) begin
            wt_base_d  = wt_base;
            act_base_d = act_base;
            out_base_d = out_base;
            len_d      = act_len;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            inst_q   <= IDLE_WORD;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            inst_q   <= inst_d;
            done_q   <= done_d;
        end
    end

    // Run parameters carry no control meaning outside a run: no reset.
    always_ff @(posedge clk) begin
        wt_base_q  <= wt_base_d;
        act_base_q <= act_base_d;
        out_base_q <= out_base_d;
        len_q      <= len_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_cnt_d = rd_cnt_q + 11'(rd_fire);
        wr_cnt_d = wr_cnt_q + 11'(wr_fire);

        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                rd_cnt_d = '0;
                wr_cnt_d = '0;
                if (start) begin
                    state_d = S_WT_RD;
                end
            end
            // ROW reads plus one extra cycle to catch the last read's data.
            S_WT_RD: begin
                if (cnt_q == ROW_LAST) begin
                    state_d = S_KER_LD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_KER_LD: begin
                if (cnt_q == ROW_M1) begin
                    state_d = S_KER_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_KER_WAIT: begin
                if (cnt_q == ROW_M1) begin
                    cnt_d   = '0;
                    state_d = (len_q == 11'd0) ? S_DONE : S_ACT_RD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACT_RD: begin
                if (cnt_q == CNT_W'(len_q)) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                if ((cnt_q + 1'b1) == CNT_W'(len_q)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Array latency is data dependent; wait for the FIFO itself.
            S_DRAIN: begin
                if (ofifo_valid) begin
                    state_d = S_OUT;
                end
            end
            // Leave once the final write has been presented on inst.
            S_OUT: begin
                if (wr_cnt_q == len_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // The word is built for the state being entered so that inst is a pure
    // register aligned with state_q.
    always_comb begin
        inst_d = IDLE_WORD;
        done_d = 1'b0;

        case (state_d)
            S_WT_RD: begin
                if (cnt_d < ROW_LAST) begin
                    inst_d[32]    = 1'b0;
                    inst_d[30:20] = wt_base_d + cnt_d[10:0];
                    inst_d[34]    = 1'b1;
                end
                if (cnt_d != '0) begin
                    inst_d[2] = 1'b1;
                end
            end
            S_KER_LD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_ACT_RD: begin
                if (cnt_d < CNT_W'(len_d)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = act_base_d + cnt_d[10:0];
                end
                if (cnt_d != '0) begin
                    inst_d[2] = 1'b1;
                end
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_OUT: begin
                inst_d[6] = rd_fire;
                if (wr_fire) begin
                    inst_d[50]    = 1'b0;
                    inst_d[49]    = 1'b0;
                    inst_d[48:38] = out_base_q + wr_cnt_q;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                inst_d = IDLE_WORD;
            end
        endcase
    end

    assign inst = inst_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_ws_tile_sequencer.sv
module tb_ws_tile_sequencer;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam logic [51:0] IDLE_W = 52'h6_0009_800C_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] wt_base;
    logic [10:0] act_base;
    logic [10:0] out_base;
    logic [10:0] act_len;
    logic        ofifo_valid;
    logic [51:0] inst;
    logic        busy;
    logic        done;

    ws_tile_sequencer #(.ROW(ROW), .COL(COL)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .wt_base     (wt_base),
        .act_base    (act_base),
        .out_base    (out_base),
        .act_len     (act_len),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One run: inputs plus the expected cycle of the done pulse
    // (cycle 1 = first cycle after the start edge).
    typedef struct {
        logic [10:0] wt;
        logic [10:0] act;
        logic [10:0] outb;
        logic [10:0] len;
        int          dw;    // DRAIN cycles with ofifo_valid low before it rises
        logic [15:0] pat;   // ofifo_valid in OUT cycle o (bit o; 1 beyond 15)
        int          exp_done;
    } rec_t;

    // Expected per-cycle outputs and the ofifo_valid to drive in that cycle.
    typedef struct {
        logic [51:0] word;
        logic        busy;
        logic        done;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic push(input logic [51:0] w, input logic b, input logic d, input logic v);
        exp_t e;
        e.word = w; e.busy = b; e.done = d; e.v = v;
        sb.push_back(e);
    endtask

    // Builds the expected instruction stream of one run phase by phase.
    task automatic build(input rec_t r);
        logic [51:0] w;
        int rd, wr, o;
        logic fire_prev, rd_prev, v, fire;
        for (int i = 0; i <= ROW; i++) begin
            w = IDLE_W;
            if (i < ROW) begin
                w[32] = 1'b0; w[30:20] = r.wt + 11'(i); w[34] = 1'b1;
            end
            if (i >= 1) w[2] = 1'b1;
            push(w, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < ROW; i++) push(IDLE_W | 52'h9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < ROW; i++) push(IDLE_W, 1'b1, 1'b0, 1'b0);
        if (r.len != 0) begin
            for (int j = 0; j <= int'(r.len); j++) begin
                w = IDLE_W;
                if (j < int'(r.len)) begin
                    w[19] = 1'b0; w[17:7] = r.act + 11'(j);
                end
                if (j >= 1) w[2] = 1'b1;
                push(w, 1'b1, 1'b0, 1'b0);
            end
            for (int j = 0; j < int'(r.len); j++) push(IDLE_W | 52'hA, 1'b1, 1'b0, 1'b0);
            for (int d = 0; d <= r.dw; d++) push(IDLE_W, 1'b1, 1'b0, (d == r.dw));
            rd = 0; wr = 0; o = 0; fire_prev = 1'b0; rd_prev = 1'b0;
            while (o < 200) begin
                w = IDLE_W;
                w[6] = fire_prev;
                if (rd_prev) begin
                    w[50] = 1'b0; w[49] = 1'b0; w[48:38] = r.outb + 11'(wr);
                    wr++;
                end
                v = (o < 16) ? r.pat[o] : 1'b1;
                fire = v && (rd < int'(r.len));
                if (fire) rd++;
                push(w, 1'b1, 1'b0, v);
                rd_prev = w[6];
                fire_prev = fire;
                o++;
                if (wr == int'(r.len)) break;
            end
        end
        push(IDLE_W, 1'b1, 1'b1, 1'b0);
        push(IDLE_W, 1'b0, 1'b0, 1'b0);
        push(IDLE_W, 1'b0, 1'b0, 1'b0);
    endtask

    // Drives one run while scrambling the run inputs and pulsing a second
    // start mid-run; compares every cycle against the scoreboard.
    task automatic run(input rec_t r, input int id);
        exp_t e;
        int   idx, done_at;
        build(r);
        wt_base = r.wt; act_base = r.act; out_base = r.outb; act_len = r.len;
        ofifo_valid = 1'b0;
        start = 1'b1;
        idx = 0; done_at = -1;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            idx++;
            start    = (idx == 3);
            wt_base  = 11'($urandom);
            act_base = 11'($urandom);
            out_base = 11'($urandom);
            act_len  = 11'($urandom);
            e = sb.pop_front();
            chk($sformatf("run%0d c%0d inst", id, idx), 64'(inst), 64'(e.word));
            chk($sformatf("run%0d c%0d busy", id, idx), 64'(busy), 64'(e.busy));
            chk($sformatf("run%0d c%0d done", id, idx), 64'(done), 64'(e.done));
            if (done === 1'b1 && done_at < 0) done_at = idx;
            ofifo_valid = e.v;
        end
        start = 1'b0;
        chk($sformatf("run%0d done_cycle", id), 64'(done_at), 64'(r.exp_done));
    endtask

    rec_t tbl[4];

    initial begin
        // wt, act, out, len, dw, pat, exp_done
        tbl[0] = '{11'd100,  11'd10,   11'd20,   11'd1, 0, 16'hFFFF, 33};
        tbl[1] = '{11'd0,    11'd2046, 11'd5,    11'd3, 0, 16'hFFFD, 40};
        tbl[2] = '{11'd2044, 11'd300,  11'd400,  11'd0, 0, 16'hFFFF, 26};
        tbl[3] = '{11'd2040, 11'd7,    11'd2045, 11'd4, 3, 16'hFFDA, 48};

        reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
        wt_base = '0; act_base = '0; out_base = '0; act_len = '0;
        #2 reset = 1'b1;
        #1;
        chk("reset inst", 64'(inst), 64'(IDLE_W));
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("idle inst", 64'(inst), 64'(IDLE_W));
            chk("idle busy", 64'(busy), 64'd0);
        end

        for (int k = 0; k < 4; k++) run(tbl[k], k);

        // Abort mid-EXEC with a simultaneous start request.
        wt_base = 11'd50; act_base = 11'd60; out_base = 11'd70; act_len = 11'd5;
        start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("exec inst", 64'(inst), 64'(IDLE_W | 52'hA));
        chk("exec busy", 64'(busy), 64'd1);
        #3 reset = 1'b1; start = 1'b1;
        #1;
        chk("abort inst", 64'(inst), 64'(IDLE_W));
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post-abort inst", 64'(inst), 64'(IDLE_W));
            chk("post-abort busy", 64'(busy), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
